uart_echo_engine: RTL and testbench

- Parametrised echo/transform engine between the UART's FIFO-side interface (rx_empty/r_data/rd_uart and tx_full/w_data/wr_uart) and board I/O.
- Pops received words, applies a run-time selectable transform, and pushes results to the transmit FIFO. Transforms: pass, add-constant, uppercase, or line reversal through an internal LIFO.
- Supports auto or single-step operation, and exposes counters and status for LED/seven-segment display.

---
 rtl/uart_echo_pkg.sv | 25 ++
 rtl/uart_echo_engine_stack.sv | 66 ++++++
 rtl/uart_echo_engine.sv | 183 ++++++++++++++++++
 tb/tb_uart_echo_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and character constants for the UART echo/transform engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_echo_pkg;

  // Run-time transform selector, encoded to match the 2-bit mode input.
  typedef enum logic [1:0] {
    PASS  = 2'b00,
    ADD   = 2'b01,
    REV   = 2'b10,
    UPPER = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    FILL  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [7:0] ASCII_LO_A = 8'h61;
  localparam logic [7:0] ASCII_LO_Z = 8'h7A;
  localparam logic [7:0] CASE_OFF   = 8'h20;

endpackage

// File: rtl/uart_echo_engine_stack.sv
// Line-reversal LIFO: DEPTH words of W bits, synchronous write, combinational top.
// Latency: push/pop take effect at the next clock; o_top reflects the new top right after.
// Backpressure: pushes while full and pops while empty are ignored; push wins over pop.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointer only)
//   i_push, i_din    push i_din onto the stack
//   i_pop            discard the top word
//   i_clear          synchronous pointer clear
//   o_top            word at ptr-1 (don't-care when empty)
//   o_ptr            occupancy, 0..DEPTH
//   o_full, o_empty  occupancy flags
module echo_line_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_top,
  output logic [PW-1:0] o_ptr,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [AW-1:0] w_top_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_ptr == PW'(DEPTH));
  assign o_empty   = (r_ptr == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty && !i_push;
  // DEPTH is a power of two, so the low pointer bits minus one wrap to DEPTH-1 when full.
  assign w_top_idx = r_ptr[AW-1:0] - AW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_ptr     = r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PW'(1);
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - PW'(1);
    end
  end

  // Storage needs no reset: only words below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_ptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Echo/transform engine between UART rx/tx FIFOs: PASS, ADD, UPPER or line reversal (REV).
// Latency: pop-to-push 1 cycle (one word per 2 cycles); REV drains one word per cycle.
// Backpressure: tx_full stalls the registered w_data/wr_uart; rx pops only in IDLE/FILL.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   en, step, mode                  pop enable, single-step pulse (AUTO=0), transform select
//   rx_empty, r_data, rd_uart       show-ahead rx FIFO side; rd_uart pops the head
//   tx_full, w_data, wr_uart        tx FIFO side; wr_uart pushes w_data
//   busy, line_trunc                not-IDLE flag, sticky line-overflow flag
//   rx_cnt, tx_cnt                  wrapping pop/push counters
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          LINE_DEPTH = 16,
  parameter int unsigned TERM       = 8'h0D,
  parameter int unsigned ADD_VAL    = 1,
  parameter int          AUTO       = 1,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [DATA_W-1:0] w_data,
  output logic              wr_uart,
  output logic              busy,
  output logic              line_trunc,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [CNT_W-1:0]  tx_cnt
);

  localparam int                PW     = $clog2(LINE_DEPTH) + 1;
  localparam logic [DATA_W-1:0] TERM_W = DATA_W'(TERM);
  localparam logic [DATA_W-1:0] ADD_W  = DATA_W'(ADD_VAL);
  localparam logic [DATA_W-1:0] LO_A   = DATA_W'(ASCII_LO_A);
  localparam logic [DATA_W-1:0] LO_Z   = DATA_W'(ASCII_LO_Z);
  localparam logic [DATA_W-1:0] OFF    = DATA_W'(CASE_OFF);

  state_t              r_state;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wvld;
  logic                r_term_seen;
  logic                r_trunc;
  logic [CNT_W-1:0]    r_rx_cnt;
  logic [CNT_W-1:0]    r_tx_cnt;

  mode_t               w_mode;
  logic                w_take_ok;
  logic                w_take;
  logic                w_push;
  logic                w_slot;
  logic                w_stk_push;
  logic                w_stk_pop;
  logic                w_stk_clear;
  logic [DATA_W-1:0]   w_stk_top;
  logic [PW-1:0]       w_stk_ptr;
  logic                w_stk_full;
  logic                w_stk_empty;

  function automatic logic [DATA_W-1:0] xform(input mode_t m, input logic [DATA_W-1:0] d);
    case (m)
      ADD:     return d + ADD_W;
      UPPER:   return (d >= LO_A && d <= LO_Z) ? d - OFF : d;
      default: return d;
    endcase
  endfunction

  assign w_mode = mode_t'(mode);

  // Pops happen only where a word can be consumed: IDLE in a non-REV mode, or FILL with room.
  assign w_take_ok = ((r_state == IDLE) && (w_mode != REV)) ||
                     ((r_state == FILL) && !w_stk_full);
  // reset gates the pop strobe so the rx FIFO is never popped while the engine is held.
  assign w_take    = !reset && en && !rx_empty && ((AUTO != 0) || step) && w_take_ok;

  // The output register is a one-word skid: it may reload in the same cycle it is pushed,
  // which lets DRAIN emit one word per cycle while w_data stays registered.
  assign w_push = r_wvld && !tx_full;
  assign w_slot = !r_wvld || w_push;

  assign w_stk_push  = (r_state == FILL) && w_take && (r_data != TERM_W);
  assign w_stk_pop   = (r_state == DRAIN) && w_slot && !w_stk_empty;
  assign w_stk_clear = (r_state == IDLE) && (w_mode == REV);

  echo_line_stack #(
    .DEPTH (LINE_DEPTH),
    .W     (DATA_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_stk_push),
    .i_pop   (w_stk_pop),
    .i_clear (w_stk_clear),
    .i_din   (r_data),
    .o_top   (w_stk_top),
    .o_ptr   (w_stk_ptr),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wdata     <= '0;
      r_wvld      <= 1'b0;
      r_term_seen <= 1'b0;
      r_trunc     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mode == REV) begin
            r_state <= FILL;
          end else if (w_take) begin
            r_wdata <= xform(w_mode, r_data);
            r_wvld  <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (w_push) begin
            r_wvld  <= 1'b0;
            r_state <= IDLE;
          end
        end
        FILL: begin
          if (w_take) begin
            if (r_data == TERM_W) begin
              r_term_seen <= 1'b1;
              r_state     <= DRAIN;
            end else if (w_stk_ptr == PW'(LINE_DEPTH - 1)) begin
              // This push fills the buffer: flush it without a terminator.
              r_term_seen <= 1'b0;
              r_trunc     <= 1'b1;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_slot) begin
            if (!w_stk_empty) begin
              r_wdata <= w_stk_top;
              r_wvld  <= 1'b1;
            end else if (r_term_seen) begin
              r_wdata     <= TERM_W;
              r_wvld      <= 1'b1;
              r_term_seen <= 1'b0;
            end else begin
              r_wvld  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_cnt <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_take) r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      if (w_push) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
    end
  end

  assign rd_uart    = w_take;
  assign wr_uart    = w_push;
  assign w_data     = r_wdata;
  assign busy       = (r_state != IDLE);
  assign line_trunc = r_trunc;
  assign rx_cnt     = r_rx_cnt;
  assign tx_cnt     = r_tx_cnt;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench: three engines (default, LINE_DEPTH=4, AUTO=0) on private rx/tx FIFO models.
module tb_uart_echo_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, step, tx_full;
  logic [1:0] mode;
  logic [2:0] rx_empty, rd_uart, wr_uart, busy, trunc;
  logic [7:0] r_data [3];
  logic [7:0] w_data [3];
  logic [15:0] rx_cnt [3];
  logic [15:0] tx_cnt [3];

  logic [7:0] rxq0[$], rxq1[$], rxq2[$];
  logic [7:0] txq0[$], txq1[$], txq2[$];
  int rx_rd [3];

  int checks = 0;
  int errors = 0;
  int coincide = 0;

  uart_echo_engine #(.LINE_DEPTH(16), .AUTO(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .step(step), .mode(mode),
    .rx_empty(rx_empty[0]), .r_data(r_data[0]), .rd_uart(rd_uart[0]),
    .tx_full(tx_full), .w_data(w_data[0]), .wr_uart(wr_uart[0]),
    .busy(busy[0]), .line_trunc(trunc[0]), .rx_cnt(rx_cnt[0]), .tx_cnt(tx_cnt[0]));

  uart_echo_engine #(.LINE_DEPTH(4), .AUTO(1)) dut4 (
    .clk(clk), .reset(reset), .en(en), .step(step), .mode(mode),
    .rx_empty(rx_empty[1]), .r_data(r_data[1]), .rd_uart(rd_uart[1]),
    .tx_full(tx_full), .w_data(w_data[1]), .wr_uart(wr_uart[1]),
    .busy(busy[1]), .line_trunc(trunc[1]), .rx_cnt(rx_cnt[1]), .tx_cnt(tx_cnt[1]));

  uart_echo_engine #(.LINE_DEPTH(16), .AUTO(0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .step(step), .mode(mode),
    .rx_empty(rx_empty[2]), .r_data(r_data[2]), .rd_uart(rd_uart[2]),
    .tx_full(tx_full), .w_data(w_data[2]), .wr_uart(wr_uart[2]),
    .busy(busy[2]), .line_trunc(trunc[2]), .rx_cnt(rx_cnt[2]), .tx_cnt(tx_cnt[2]));

  function automatic int rxq_size(input int i);
    case (i)
      0: return rxq0.size();
      1: return rxq1.size();
      default: return rxq2.size();
    endcase
  endfunction

  function automatic logic [7:0] rxq_at(input int i, input int k);
    case (i)
      0: return rxq0[k];
      1: return rxq1[k];
      default: return rxq2[k];
    endcase
  endfunction

  function automatic int tx_size(input int i);
    case (i)
      0: return txq0.size();
      1: return txq1.size();
      default: return txq2.size();
    endcase
  endfunction

  function automatic logic [7:0] get_tx(input int i, input int k);
    if (k >= tx_size(i)) return 8'hxx;
    case (i)
      0: return txq0[k];
      1: return txq1[k];
      default: return txq2[k];
    endcase
  endfunction

  task automatic rx_push(input int i, input logic [7:0] b);
    case (i)
      0: rxq0.push_back(b);
      1: rxq1.push_back(b);
      default: rxq2.push_back(b);
    endcase
  endtask

  // Show-ahead rx FIFO model: pop on rd_uart at the edge, present the new head 1 time unit later.
  initial for (int i = 0; i < 3; i++) rx_rd[i] = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (rd_uart[i] === 1'b1) rx_rd[i] = rx_rd[i] + 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      rx_empty[i] = !(rx_rd[i] < rxq_size(i));
      r_data[i]   = rx_empty[i] ? 8'h00 : rxq_at(i, rx_rd[i]);
    end
  end

  always @(posedge clk) begin
    if (wr_uart[0] === 1'b1) txq0.push_back(w_data[0]);
    if (wr_uart[1] === 1'b1) txq1.push_back(w_data[1]);
    if (wr_uart[2] === 1'b1) txq2.push_back(w_data[2]);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (rd_uart[i] === 1'b1 && wr_uart[i] === 1'b1) coincide++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int i, input int n, input int budget);
    int c;
    c = 0;
    while (tx_size(i) < n && c < budget) begin @(negedge clk); c++; end
  endtask

  task automatic wait_rxcnt(input int i, input logic [15:0] n, input int budget);
    int c;
    c = 0;
    while (rx_cnt[i] !== n && c < budget) begin @(negedge clk); c++; end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; step = 1'b0; tx_full = 1'b0; mode = 2'b00;
    cyc(2);
    checks++;
    if ({rd_uart, wr_uart, busy, trunc} !== 12'h000) begin
      errors++; $display("FAIL reset_flags: got %h want 000", {rd_uart, wr_uart, busy, trunc});
    end
    checks++;
    if (rx_cnt[0] !== 16'd0 || tx_cnt[0] !== 16'd0 || w_data[0] !== 8'h00) begin
      errors++; $display("FAIL reset_regs: rx %0d tx %0d wd %h want 0 0 00", rx_cnt[0], tx_cnt[0], w_data[0]);
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_pass;
    int pulses, b2b;
    logic prev;
    pulses = 0; b2b = 0; prev = 1'b0;
    mode = 2'b00;
    rx_push(0, 8'h41); rx_push(0, 8'h42);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd_uart[0] === 1'b1) begin pulses++; if (prev) b2b++; end
      prev = (rd_uart[0] === 1'b1);
    end
    checks++;
    if (pulses != 2 || b2b != 0) begin
      errors++; $display("FAIL pass_rd_pulses: got %0d pulses %0d back-to-back want 2 0", pulses, b2b);
    end
    checks++;
    if (get_tx(0, 0) !== 8'h41 || get_tx(0, 1) !== 8'h42 || tx_size(0) != 2) begin
      errors++; $display("FAIL pass_data: got %h %h n=%0d want 41 42 n=2", get_tx(0, 0), get_tx(0, 1), tx_size(0));
    end
    checks++;
    if (rx_cnt[0] !== 16'd2 || tx_cnt[0] !== 16'd2) begin
      errors++; $display("FAIL pass_counts: rx %0d tx %0d want 2 2", rx_cnt[0], tx_cnt[0]);
    end
  endtask

  task automatic test_add_upper;
    int base;
    mode = 2'b01;
    base = tx_size(0);
    rx_push(0, 8'hFF); rx_push(0, 8'h30);
    wait_tx(0, base + 2, 40);
    checks++;
    if (get_tx(0, base) !== 8'h00 || get_tx(0, base + 1) !== 8'h31) begin
      errors++; $display("FAIL add_wrap: got %h %h want 00 31", get_tx(0, base), get_tx(0, base + 1));
    end
    cyc(2);
    mode = 2'b11;
    base = tx_size(0);
    rx_push(0, 8'h61); rx_push(0, 8'h5A); rx_push(0, 8'h7B);
    wait_tx(0, base + 3, 40);
    checks++;
    if (get_tx(0, base) !== 8'h41 || get_tx(0, base + 1) !== 8'h5A || get_tx(0, base + 2) !== 8'h7B) begin
      errors++; $display("FAIL upper: got %h %h %h want 41 5a 7b",
                         get_tx(0, base), get_tx(0, base + 1), get_tx(0, base + 2));
    end
  endtask

  task automatic test_backpressure;
    int base, bad, c;
    cyc(2);
    mode = 2'b00;
    tx_full = 1'b1;
    base = tx_size(0);
    rx_push(0, 8'h55);
    c = 0;
    while (busy[0] !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL bp_enter_write: busy %b want 1", busy[0]);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_uart[0] !== 1'b0 || w_data[0] !== 8'h55) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d bad cycles want 0", bad);
    end
    tx_full = 1'b0;
    #1;
    checks++;
    if (wr_uart[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release: wr_uart %b want 1", wr_uart[0]);
    end
    @(negedge clk);
    checks++;
    if (get_tx(0, base) !== 8'h55 || tx_size(0) != base + 1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL bp_data: got %h n=%0d busy %b want 55 n=%0d busy 0",
                         get_tx(0, base), tx_size(0), busy[0], base + 1);
    end
  endtask

  task automatic test_step;
    rx_push(2, 8'h11); rx_push(2, 8'h22); rx_push(2, 8'h33);
    cyc(3);
    step = 1'b1;          // pops 0x11
    cyc(1);               // still high while in WRITE: dropped
    cyc(1);
    step = 1'b0;
    cyc(4);
    step = 1'b1;          // pops 0x22
    cyc(1);
    step = 1'b0;
    cyc(8);
    checks++;
    if (rx_cnt[2] !== 16'd2 || rx_rd[2] != 2) begin
      errors++; $display("FAIL step_pops: rx_cnt %0d fifo pops %0d want 2 2", rx_cnt[2], rx_rd[2]);
    end
    checks++;
    if (get_tx(2, 0) !== 8'h11 || get_tx(2, 1) !== 8'h22 || tx_size(2) != 2) begin
      errors++; $display("FAIL step_data: got %h %h n=%0d want 11 22 n=2", get_tx(2, 0), get_tx(2, 1), tx_size(2));
    end
  endtask

  task automatic test_rev;
    int base;
    mode = 2'b10;
    cyc(2);
    base = tx_size(0);
    rx_push(0, 8'h61); rx_push(0, 8'h62); rx_push(0, 8'h63); rx_push(0, 8'h0D);
    wait_tx(0, base + 4, 60);
    checks++;
    if (get_tx(0, base) !== 8'h63 || get_tx(0, base + 1) !== 8'h62 ||
        get_tx(0, base + 2) !== 8'h61 || get_tx(0, base + 3) !== 8'h0D) begin
      errors++; $display("FAIL rev_line: got %h %h %h %h want 63 62 61 0d", get_tx(0, base),
                         get_tx(0, base + 1), get_tx(0, base + 2), get_tx(0, base + 3));
    end
    base = tx_size(0);
    rx_push(0, 8'h0D);
    wait_tx(0, base + 1, 40);
    cyc(6);
    checks++;
    if (get_tx(0, base) !== 8'h0D || tx_size(0) != base + 1) begin
      errors++; $display("FAIL rev_empty_line: got %h n=%0d want 0d n=%0d", get_tx(0, base), tx_size(0), base + 1);
    end
    checks++;
    if (trunc[0] !== 1'b0) begin
      errors++; $display("FAIL rev_no_trunc: line_trunc %b want 0", trunc[0]);
    end
  endtask

  task automatic test_trunc;
    rx_push(1, 8'h77); rx_push(1, 8'h78); rx_push(1, 8'h79); rx_push(1, 8'h7A); rx_push(1, 8'h71);
    wait_tx(1, 4, 60);
    cyc(10);
    checks++;
    if (get_tx(1, 0) !== 8'h7A || get_tx(1, 1) !== 8'h79 || get_tx(1, 2) !== 8'h78 ||
        get_tx(1, 3) !== 8'h77 || tx_size(1) != 4) begin
      errors++; $display("FAIL trunc_data: got %h %h %h %h n=%0d want 7a 79 78 77 n=4",
                         get_tx(1, 0), get_tx(1, 1), get_tx(1, 2), get_tx(1, 3), tx_size(1));
    end
    checks++;
    if (trunc[1] !== 1'b1 || rx_cnt[1] !== 16'd5 || busy[1] !== 1'b1) begin
      errors++; $display("FAIL trunc_state: trunc %b rx %0d busy %b want 1 5 1", trunc[1], rx_cnt[1], busy[1]);
    end
  endtask

  task automatic test_mode_switch;
    int base;
    tx_full = 1'b1;
    base = tx_size(0);
    rx_push(0, 8'h70); rx_push(0, 8'h71); rx_push(0, 8'h72); rx_push(0, 8'h0D);
    wait_rxcnt(0, 16'd17, 40);
    cyc(3);
    mode = 2'b00;
    cyc(3);
    tx_full = 1'b0;
    wait_tx(0, base + 4, 40);
    cyc(4);
    checks++;
    if (get_tx(0, base) !== 8'h72 || get_tx(0, base + 1) !== 8'h71 || get_tx(0, base + 2) !== 8'h70 ||
        get_tx(0, base + 3) !== 8'h0D || tx_size(0) != base + 4) begin
      errors++; $display("FAIL switch_drain: got %h %h %h %h n=%0d want 72 71 70 0d n=%0d", get_tx(0, base),
                         get_tx(0, base + 1), get_tx(0, base + 2), get_tx(0, base + 3), tx_size(0), base + 4);
    end
    checks++;
    if (busy[0] !== 1'b0 || rx_cnt[0] !== 16'd17 || tx_cnt[0] !== 16'd17) begin
      errors++; $display("FAIL switch_idle: busy %b rx %0d tx %0d want 0 17 17", busy[0], rx_cnt[0], tx_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_drain;
    int base;
    mode = 2'b10;
    cyc(2);
    tx_full = 1'b1;
    rx_push(0, 8'h41); rx_push(0, 8'h42); rx_push(0, 8'h0D);
    wait_rxcnt(0, 16'd20, 40);
    cyc(2);
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_uart, wr_uart, busy, trunc} !== 12'h000) begin
      errors++; $display("FAIL rst_drain_flags: got %h want 000", {rd_uart, wr_uart, busy, trunc});
    end
    checks++;
    if (rx_cnt[0] !== 16'd0 || tx_cnt[0] !== 16'd0 || w_data[0] !== 8'h00) begin
      errors++; $display("FAIL rst_drain_regs: rx %0d tx %0d wd %h want 0 0 00", rx_cnt[0], tx_cnt[0], w_data[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    tx_full = 1'b0;
    cyc(2);
    base = tx_size(0);
    rx_push(0, 8'h43); rx_push(0, 8'h44); rx_push(0, 8'h0D);
    wait_tx(0, base + 3, 60);
    cyc(6);
    checks++;
    if (get_tx(0, base) !== 8'h44 || get_tx(0, base + 1) !== 8'h43 || get_tx(0, base + 2) !== 8'h0D ||
        tx_size(0) != base + 3) begin
      errors++; $display("FAIL rst_clean_line: got %h %h %h n=%0d want 44 43 0d n=%0d", get_tx(0, base),
                         get_tx(0, base + 1), get_tx(0, base + 2), tx_size(0), base + 3);
    end
    checks++;
    if (rx_cnt[0] !== 16'd3 || tx_cnt[0] !== 16'd3) begin
      errors++; $display("FAIL rst_counts: rx %0d tx %0d want 3 3", rx_cnt[0], tx_cnt[0]);
    end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_add_upper;
    test_backpressure;
    test_step;
    test_rev;
    test_trunc;
    test_mode_switch;
    test_reset_mid_drain;
    checks++;
    if (coincide != 0) begin
      errors++; $display("FAIL rd_wr_overlap: %0d cycles want 0", coincide);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
